// File: rtl/shift_pkg.sv
// Shared constants, buffer-state encoding and entry layout for the RV32I shift issue stage.
// Optional encoding check is enabled by defining SHIFT_ILLEGAL_CHECK_EN.
package shift_pkg;

    localparam int XLEN_P    = 32;
    localparam int SHAMT_W_P = 5;

    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SRX  = 3'b101;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_SRA  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [XLEN_P-1:0] result;
        logic [4:0]        rd;
        logic              illegal;
    } shift_entry_t;

    localparam int ENTRY_W = $bits(shift_entry_t);

    // SLL only accepts the base funct7; SRL/SRA accept base or SRA pattern.
    function automatic logic shift_is_illegal(input logic [2:0] f3, input logic [6:0] f7);
        logic bad;
        bad = 1'b0;
        if (f3 != FUNCT3_SLL && f3 != FUNCT3_SRX) bad = 1'b1;
        if (f7 != FUNCT7_BASE && f7 != FUNCT7_SRA) bad = 1'b1;
        if (f3 == FUNCT3_SLL && f7 == FUNCT7_SRA) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/BarrelShifter.sv
// Combinational 32-bit barrel shifter: logical left, logical right, arithmetic right.
module BarrelShifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [XLEN-1:0]    i_a,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_right,
    input  logic               i_arith,
    output logic [XLEN-1:0]    o_y
);
    logic [XLEN:0] w_ext;
    logic [XLEN:0] w_sr;

    // One extra sign bit lets a single arithmetic shift serve both SRL and SRA.
    assign w_ext = {i_arith & i_a[XLEN-1], i_a};
    assign w_sr  = $unsigned($signed(w_ext) >>> i_shamt);
    assign o_y   = i_right ? w_sr[XLEN-1:0] : (i_a << i_shamt);

endmodule

// File: rtl/shift_skid_buffer.sv
// Generic 2-entry valid/ready output buffer (OUT + SKID); upstream ready depends only on state.
module shift_skid_buffer
    import shift_pkg::*;
#(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    buf_state_e   r_state;
    buf_state_e   w_next;
    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;
    logic         w_accept;
    logic         w_pop;
    logic         w_load_out;
    logic         w_load_skid;
    logic         w_move;

    assign o_ready  = (r_state != ST_TWO);
    assign o_valid  = (r_state != ST_EMPTY);
    assign o_data   = r_out;
    assign w_accept = i_valid & o_ready;
    assign w_pop    = o_valid & i_ready;

    always_comb begin
        w_next      = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_move      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next     = ST_ONE;
                    w_load_out = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_next      = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_next = ST_ONE;
                    w_move = 1'b1;
                end
            end
            default: w_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out)  r_out <= i_data;
            else if (w_move) r_out <= r_skid;
            if (w_load_skid) r_skid <= i_data;
        end
    end

endmodule

// File: rtl/shift_issue_stage.sv
// RV32I shift-group execute front end: decode, barrel shift, 2-entry registered output.
// Define SHIFT_ILLEGAL_CHECK_EN to flag bad shift encodings (flagged result forced to 0).
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            is_imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [11:0]     imm,
    input  logic [4:0]      rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);
    logic               w_right;
    logic [6:0]         w_f7;
    logic               w_arith;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]    w_shifted;
    shift_entry_t       w_entry;
    shift_entry_t       w_head;
    logic [ENTRY_W-1:0] w_head_bits;

    assign w_right = funct3[2];
    assign w_f7    = is_imm ? imm[11:5] : funct7;
    assign w_arith = w_right & w_f7[5];
    assign w_shamt = is_imm ? imm[SHAMT_W-1:0] : rs2_val[SHAMT_W-1:0];

    BarrelShifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shifter (
        .i_a     (rs1_val),
        .i_shamt (w_shamt),
        .i_right (w_right),
        .i_arith (w_arith),
        .o_y     (w_shifted)
    );

`ifdef SHIFT_ILLEGAL_CHECK_EN
    logic w_illegal;
    assign w_illegal      = shift_is_illegal(funct3, w_f7);
    assign w_entry.result = w_illegal ? '0 : w_shifted;
    assign w_entry.illegal = w_illegal;
`else
    assign w_entry.result  = w_shifted;
    assign w_entry.illegal = 1'b0;
`endif
    assign w_entry.rd = rd;

    shift_skid_buffer #(.W(ENTRY_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_entry),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_head_bits)
    );

    assign w_head      = w_head_bits;
    assign out_result  = w_head.result;
    assign out_rd      = w_head.rd;
    assign out_illegal = w_head.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed and streaming bench for shift_issue_stage with a bit-serial shift reference.
module tb_shift_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic        is_imm = 1'b0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [11:0] imm = '0;
    logic [4:0]  rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0]  s_f3  [16];
    logic [6:0]  s_f7  [16];
    logic        s_imm [16];
    logic [31:0] s_a   [16];
    logic [31:0] s_b   [16];
    logic [11:0] s_iv  [16];
    logic [4:0]  s_rd  [16];
    logic [31:0] s_exp [16];

    shift_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .funct7(funct7), .is_imm(is_imm), .rs1_val(rs1_val),
        .rs2_val(rs2_val), .imm(imm), .rd(rd), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] f3, input logic [6:0] f7, input logic imm_form,
                          input logic [31:0] a, input logic [31:0] b, input logic [11:0] iv,
                          input logic [4:0] r);
        funct3 = f3; funct7 = f7; is_imm = imm_form;
        rs1_val = a; rs2_val = b; imm = iv; rd = r;
        in_valid = 1'b1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int sh,
                                              input logic right, input logic arith);
        logic [31:0] r;
        r = a;
        for (int i = 0; i < sh; i++) begin
            if (right) r = {arith ? r[31] : 1'b0, r[31:1]};
            else       r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    task automatic run_stream(input bit rand_ready);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        logic [36:0] q[$];
        logic [36:0] e;
        while ((sent < 16 || q.size() > 0) && cyc < 300) begin
            if (sent < 16)
                set_op(s_f3[sent], s_f7[sent], s_imm[sent], s_a[sent], s_b[sent], s_iv[sent], s_rd[sent]);
            else
                in_valid = 1'b0;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("stream_spurious_out", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("stream_result", out_result, e[31:0]);
                    chk("stream_rd", {27'd0, out_rd}, {27'd0, e[36:32]});
                    got++;
                end
            end
            if (!rand_ready && in_valid) chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (in_valid && in_ready) begin
                q.push_back({s_rd[sent], s_exp[sent]});
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_timeout", {31'd0, cyc < 300}, 32'd1);
        chk("stream_count", got, 32'd16);
        if (!rand_ready) chk("stream_cycles", cyc, 32'd17);
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        tick(); tick();
        rst = 1'b0;

        // SRLI
        out_ready = 1'b1;
        set_op(3'b101, 7'h00, 1'b1, 32'h00000116, 32'h0, 12'h003, 5'd7);
        #1 chk("srli_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("srli_valid", {31'd0, out_valid}, 32'd1);
        chk("srli_result", out_result, 32'h00000022);
        chk("srli_rd", {27'd0, out_rd}, 32'd7);
        tick();
        chk("srli_drained", {31'd0, out_valid}, 32'd0);

        // SRA then SRL with same operands
        set_op(3'b101, 7'h20, 1'b0, 32'h80000000, 32'h00000024, 12'h0, 5'd3);
        tick();
        chk("sra_result", out_result, 32'hF8000000);
        set_op(3'b101, 7'h00, 1'b0, 32'h80000000, 32'h00000024, 12'h0, 5'd3);
        tick();
        in_valid = 1'b0;
        chk("srl_result", out_result, 32'h08000000);
        tick();

        // backpressure: 1<<0, 1<<1, 1<<2 offered with out_ready low
        out_ready = 1'b0;
        set_op(3'b001, 7'h00, 1'b0, 32'd1, 32'd0, 12'h0, 5'd1);
        #1 chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_first", out_result, 32'd1);
        set_op(3'b001, 7'h00, 1'b0, 32'd1, 32'd1, 12'h0, 5'd2);
        #1 chk("bp_rdy2", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_rdy3", {31'd0, in_ready}, 32'd0);
        set_op(3'b001, 7'h00, 1'b0, 32'd1, 32'd2, 12'h0, 5'd3);
        tick();
        chk("bp_full_hold", {31'd0, in_ready}, 32'd0);
        chk("bp_stable_result", out_result, 32'd1);
        chk("bp_stable_rd", {27'd0, out_rd}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_second", out_result, 32'd2);
        chk("bp_second_rd", {27'd0, out_rd}, 32'd2);
        chk("bp_reopen", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_third", out_result, 32'd4);
        chk("bp_third_rd", {27'd0, out_rd}, 32'd3);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // reset while holding two entries
        out_ready = 1'b0;
        set_op(3'b001, 7'h00, 1'b0, 32'd1, 32'd3, 12'h0, 5'd4);
        tick();
        set_op(3'b001, 7'h00, 1'b0, 32'd1, 32'd4, 12'h0, 5'd5);
        tick();
        in_valid = 1'b0;
        chk("rst2_full", {31'd0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst2_out_result", out_result, 32'd0);
        chk("rst2_out_rd", {27'd0, out_rd}, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        set_op(3'b101, 7'h00, 1'b1, 32'h00000080, 32'h0, 12'h004, 5'd9);
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_result", out_result, 32'h00000008);
        chk("post_rst_rd", {27'd0, out_rd}, 32'd9);
        tick();
        chk("post_rst_drained", {31'd0, out_valid}, 32'd0);

        // SLLI with funct7 field = 0000001
        set_op(3'b001, 7'h00, 1'b1, 32'd5, 32'h0, 12'h020, 5'd2);
        tick();
        in_valid = 1'b0;
`ifdef SHIFT_ILLEGAL_CHECK_EN
        chk("illegal_flag", {31'd0, out_illegal}, 32'd1);
        chk("illegal_result", out_result, 32'd0);
`else
        chk("illegal_flag", {31'd0, out_illegal}, 32'd0);
        chk("illegal_result", out_result, 32'd5);
`endif
        tick();

        // random stream, full throughput then random backpressure
        for (int i = 0; i < 16; i++) begin
            logic right, sra;
            logic [4:0] sh;
            s_f3[i]  = ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b001;
            right    = s_f3[i][2];
            sra      = right & ($urandom_range(0, 1) != 0);
            s_imm[i] = ($urandom_range(0, 1) != 0);
            s_a[i]   = $urandom;
            s_b[i]   = $urandom;
            sh       = 5'($urandom_range(0, 31));
            s_iv[i]  = {sra ? 7'h20 : 7'h00, sh};
            s_f7[i]  = s_imm[i] ? 7'($urandom) : (sra ? 7'h20 : 7'h00);
            s_rd[i]  = 5'(i + 1);
            s_exp[i] = ref_shift(s_a[i], s_imm[i] ? int'(sh) : int'(s_b[i][4:0]), right, sra);
        end
        run_stream(1'b0);
        run_stream(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Execute-stage front end for the RV32I shift group: SLL, SRL, SRA, SLLI, SRLI, SRAI.
- Decodes funct3/funct7 and the immediate into shamt/arith/right, drives the core's combinational BarrelShifter, and registers the result.
- Result is held in a 2-entry output/skid buffer with valid/ready handshakes on both sides.
- Sits between the decode/operand-read stage and writeback.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- SHAMT_W, 5, shift-amount width (log2 XLEN).

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents a shift op.
- in_ready  out  1  stage can accept the op this cycle.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7; used only for register-form ops.
- is_imm  in  1  1 = immediate form (OP-IMM), 0 = register form.
- rs1_val  in  32  value to shift.
- rs2_val  in  32  register shift amount; low 5 bits used.
- imm  in  12  I-type immediate; imm[4:0] is the shamt, imm[11:5] is the funct7 field.
- rd  in  5  destination register; carried alongside the result.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  shifted value.
- out_rd  out  5  destination register for out_result.
- out_illegal  out  1  encoding error flag; tied to 0 unless SHIFT_ILLEGAL_CHECK_EN is defined.

Behaviour:
- Decode (combinational, at accept):
  - right = funct3[2].
  - f7 = is_imm ? imm[11:5] : funct7.
  - arith = right & f7[5].
  - shamt = is_imm ? imm[4:0] : rs2_val[4:0].
  - A = rs1_val.
- Accept condition: in_valid & in_ready. The shifter output is captured at that clock edge, so latency is 1 cycle (accept at edge N, out_valid visible after N).
- Buffer holds two entries: OUT (drives the output ports) and SKID. State encoding:
  - EMPTY: nothing held.
  - ONE: OUT valid.
  - TWO: OUT and SKID valid.
- in_ready = (state != TWO); it depends only on registered state and has no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Transitions (pop = out_valid & out_ready):
  - EMPTY + accept -> ONE.
  - ONE + accept + pop -> ONE; OUT takes the new result.
  - ONE + accept, no pop -> TWO; SKID takes the new result.
  - ONE + pop, no accept -> EMPTY.
  - TWO + pop -> ONE; SKID moves to OUT. No accept is possible in TWO.
- Results leave in accept order; none dropped or duplicated. Sustained throughput with out_ready=1 is 1 op/cycle.
- While out_valid=1 and out_ready=0, OUT contents are stable.
- Reset (async assert, sync deassert by the system):
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_result=0, out_rd=0, out_illegal=0, SKID cleared.
  - Reset mid-operation discards all held results.
- funct3 values other than 001/101 are decoded purely by funct3[2]; no error is raised without the optional feature.
- out_rd and out_illegal travel with their entry through SKID.

Optional Feature:
- Macro SHIFT_ILLEGAL_CHECK_EN.
- When defined:
  - out_illegal is set for an entry if any of these hold:
    - funct3 is not 001 or 101;
    - f7 is not 0000000 or 0100000;
    - funct3=001 and f7=0100000.
  - A flagged entry carries out_result=0.
  - Handshake and ordering are unchanged.
- When undefined: out_illegal is constant 0, no check logic is generated, and out_result is always the shifter output.

Decomposition:
- Package shift_pkg holds:
  - FUNCT3_SLL=3'b001, FUNCT3_SRX=3'b101.
  - FUNCT7_BASE=7'b0000000, FUNCT7_SRA=7'b0100000.
  - State encodings ST_EMPTY, ST_ONE, ST_TWO.
  - Buffer entry layout: result, rd, illegal.
- Natural sub-module: shift_skid_buffer, a generic 2-entry valid/ready buffer parameterised on payload width.
- shift_issue_stage contains the decode logic, the BarrelShifter instance, and the buffer instance.

Test Plan:
- Reset: assert rst while in TWO -> same cycle out_valid=0, in_ready=1, out_result=0; after release, first accepted op appears normally.
- SRLI: rs1=32'h00000116, imm=12'h003, funct3=101, is_imm=1, rd=7, out_ready=1 -> next cycle out_valid=1, out_result=32'h00000022, out_rd=7.
- SRA: rs1=32'h80000000, rs2=32'h00000024, funct7=0100000, funct3=101 -> out_result=32'hF8000000; same op with funct7=0 -> 32'h08000000.
- Backpressure:
  - out_ready=0; offer SLL of 1 by 0, 1, 2 on consecutive cycles -> two accepted, in_ready=0 from the 3rd cycle.
  - Raise out_ready -> results 1, 2, then 4 in order.
- Streaming: 16 random shifts, out_ready=1 -> one result per cycle, all match a reference model. Then repeat with random out_ready -> same results in the same order.
- Illegal immediate: SLLI imm=12'h020, rs1=5.
  - With SHIFT_ILLEGAL_CHECK_EN: out_illegal=1, out_result=0.
  - Without the macro: out_illegal=0, out_result=5.
